rtl_pipelined_adder: RTL and testbench
======================================

# rtl_pipelined_adder

Parametrised, pipelined successor to the 16-bit ripple adder. It adds two WIDTH-bit operands plus carry-in. The carry chain is split into SEG-bit segments, one segment per pipeline stage, so the clock rate no longer depends on WIDTH. Operands enter and results leave through valid/ready handshakes, with full throughput and back-pressure; the block sits between operand-producing and result-consuming datapath stages.

## Interface
- WIDTH, 32: operand and sum width; must be a multiple of SEG.
- SEG, 8: segment width in bits; NSEG = WIDTH/SEG pipeline stages, NSEG ≥ 1.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block accepts the bundle this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  subtract select; present only with ADDER_SUB_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  sum.
- cout  out  1  carry-out of bit WIDTH-1.
- ovf  out  1  two's-complement signed overflow.

## Operation
- Arithmetic: {cout, s} = a + b + cin, computed modulo 2^(WIDTH+1).
  - ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]), where b_eff is the B value actually added.
- Stage k (0..NSEG-1) holds:
  - sum segments 0..k, already resolved;
  - the carry out of segment k;
  - the unconsumed upper segments of a and b_eff;
  - one valid bit.
- Stage 0 computes segment 0 from the inputs and cin. Stage k>0 computes segment k from the stage k-1 carry.
- Stage NSEG-1 registers drive s, cout, ovf and out_valid directly. There is no combinational path from a, b or cin to any output.
- advance = !out_valid || out_ready. All stages shift together when advance=1 and all hold when advance=0. Bubbles are carried, not compressed.
- in_ready = advance. This is combinational from out_ready and out_valid only, never from in_valid.
- A transfer occurs when in_valid && in_ready. When in_valid=0 and advance=1, stage 0 loads valid=0 and its data is don't-care.
- Reset clears every stage valid bit and zeroes s, cout and ovf.
  - rst asserted while transactions are in flight discards them all.
  - in_valid is ignored while rst=1.
  - in_ready follows the post-reset state: it is 1 from the first cycle after reset.

## Timing
- Latency: a bundle transferred at edge E appears with out_valid=1 after edge E+NSEG-1, i.e. NSEG edges counting E.
  - WIDTH=32, SEG=8: 4 cycles.
  - NSEG=1: 1 cycle, registered output only.
- Throughput: one bundle per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, s, cout, ovf and out_valid hold stable and every stage holds. No bundle is lost or duplicated.
- Simultaneous out_ready=1 and in_valid=1 on a full pipeline: the output retires and the input enters on the same edge.
- Results leave in acceptance order.

## Configuration
- ADDER_SUB_EN defined:
  - the `sub` port exists;
  - when sub=1 the block computes a - b, with b_eff = ~b and an effective carry-in of 1; cin is ignored;
  - cout=1 means no borrow;
  - ovf is the signed subtraction overflow;
  - sub travels with its bundle.
- ADDER_SUB_EN undefined: no `sub` port, b_eff = b, add only.

## Test plan
All scenarios use WIDTH=32, SEG=8.
- Reset then idle -> out_valid=0, s=0, cout=0, ovf=0, in_ready=1.
- Segment carry chain: a=0x00FFFFFF, b=0x00000001, cin=0 -> s=0x01000000, cout=0, ovf=0, exactly 4 cycles after the transfer.
- Wrap and overflow:
  - 0xFFFFFFFF + 0x00000001 -> s=0, cout=1, ovf=0;
  - 0x7FFFFFFF + 0x00000001 -> s=0x80000000, cout=0, ovf=1;
  - 0xFFFFFFFF + 0xFFFFFFFF with cin=1 -> s=0xFFFFFFFF, cout=1.
- Back-pressure:
  - stream 6 back-to-back bundles with out_ready held low from cycle 5 for 3 cycles;
  - in_ready=0 and outputs stable during the hold;
  - all 6 results delivered in order with correct sums;
  - throughput is 1 per cycle once released.
- Reset mid-flight: accept 3 bundles, assert rst for 1 cycle -> no out_valid afterwards for those bundles; a new bundle accepted after reset returns correctly after 4 cycles.
- With ADDER_SUB_EN:
  - sub=1, a=0x00000005, b=0x00000007 -> s=0xFFFFFFFE, cout=0;
  - sub=1, a=0x80000000, b=0x00000001 -> s=0x7FFFFFFF, ovf=1, cout=1.

Source files
------------

// File: rtl/rtl_pipelined_adder.sv
// Pipelined a + b + cin, one SEG-bit carry segment per stage; `ADDER_SUB_EN adds a sub port selecting a - b.
// Latency WIDTH/SEG cycles from transfer to out_valid; one bundle per cycle.
// Back-pressure freezes every stage together: in_ready = !out_valid || out_ready.
module rtl_pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG;

    // Per-stage state: resolved low sum segments, segment carry, operands still to be consumed.
    logic [NSEG-1:0]  vld_q;
    logic [NSEG-1:0]  cy_q;
    logic [WIDTH-1:0] sum_q [NSEG];
    logic [WIDTH-1:0] opa_q [NSEG];
    logic [WIDTH-1:0] opb_q [NSEG];
    logic             ovf_q;

    logic [NSEG-1:0]  nxt_vld;
    logic [NSEG-1:0]  nxt_cy;
    logic [WIDTH-1:0] nxt_sum [NSEG];
    logic [WIDTH-1:0] nxt_a   [NSEG];
    logic [WIDTH-1:0] nxt_b   [NSEG];
    logic             nxt_ovf;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             advance;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic             src_c;
    logic             src_v;
    logic [SEG:0]     seg_res;

    // Subtraction is folded into the operand before stage 0, so sub travels as part of b_eff.
`ifdef ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign advance  = !vld_q[NSEG-1] || out_ready;
    assign in_ready = advance;

    always_comb begin
        nxt_vld = '0;
        nxt_cy  = '0;
        nxt_ovf = 1'b0;
        src_a   = '0;
        src_b   = '0;
        src_sum = '0;
        src_c   = 1'b0;
        src_v   = 1'b0;
        seg_res = '0;
        for (int k = 0; k < NSEG; k++) begin
            nxt_sum[k] = '0;
            nxt_a[k]   = '0;
            nxt_b[k]   = '0;
        end
        for (int k = 0; k < NSEG; k++) begin
            src_a   = (k == 0) ? a       : opa_q[(k == 0) ? 0 : k - 1];
            src_b   = (k == 0) ? b_eff   : opb_q[(k == 0) ? 0 : k - 1];
            src_sum = (k == 0) ? '0      : sum_q[(k == 0) ? 0 : k - 1];
            src_c   = (k == 0) ? cin_eff : cy_q[(k == 0) ? 0 : k - 1];
            src_v   = (k == 0) ? in_valid : vld_q[(k == 0) ? 0 : k - 1];

            seg_res = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]}
                    + {{SEG{1'b0}}, src_c};

            nxt_sum[k]                = src_sum;
            nxt_sum[k][k*SEG +: SEG]  = seg_res[SEG-1:0];
            nxt_cy[k]                 = seg_res[SEG];
            nxt_a[k]                  = src_a;
            nxt_b[k]                  = src_b;
            nxt_vld[k]                = src_v;

            if (k == NSEG - 1) begin
                nxt_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (seg_res[SEG-1] != src_a[WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                sum_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= nxt_vld;
            cy_q  <= nxt_cy;
            ovf_q <= nxt_ovf;
            for (int k = 0; k < NSEG; k++) begin
                sum_q[k] <= nxt_sum[k];
                opa_q[k] <= nxt_a[k];
                opb_q[k] <= nxt_b[k];
            end
        end
    end

    assign out_valid = vld_q[NSEG-1];
    assign s         = sum_q[NSEG-1];
    assign cout      = cy_q[NSEG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rtl_pipelined_adder.sv
// Self-checking bench for rtl_pipelined_adder (WIDTH=32, SEG=8) against a plain-arithmetic reference.
module tb_rtl_pipelined_adder;

    localparam int W  = 32;
    localparam int SG = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub_sig;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          cout;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtl_pipelined_adder #(.WIDTH(W), .SEG(SG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER_SUB_EN
        .sub       (sub_sig),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: {ovf, cout, s} from unsigned and signed integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc, input logic ms);
        longint      sa, sb, sr;
        logic [32:0] u;
        logic        ov;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (ms) begin
            sr = sa - sb;
            u  = {(ma >= mb), ma - mb};
        end else begin
            sr = sa + sb + longint'(mc);
            u  = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ov, u};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Sends one bundle into an idle pipeline and reports cycles to out_valid (-1 on timeout).
    task automatic send_one(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                            input logic ts, output int lat, output logic [33:0] res);
        @(posedge clk); #1;
        a = ta; b = tb; cin = tc; sub_sig = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = {ovf, cout, s};
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub_sig = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (s !== 32'h0) begin errors++; $display("FAIL reset_s: got %h expected 00000000", s); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_directed();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic        vc [5];
        logic [33:0] res, exp;
        int          lat;
        va[0] = 32'h00FF_FFFF; vb[0] = 32'h0000_0001; vc[0] = 1'b0;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 1'b0;
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0001; vc[2] = 1'b0;
        va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; vc[3] = 1'b1;
        va[4] = 32'h8000_0000; vb[4] = 32'h8000_0000; vc[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_one(va[i], vb[i], vc[i], 1'b0, lat, res);
            exp = model(va[i], vb[i], vc[i], 1'b0);
            checks++; if (lat !== 4) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat); end
            checks++; if (res[31:0] !== exp[31:0]) begin errors++; $display("FAIL directed_s[%0d]: got %h expected %h", i, res[31:0], exp[31:0]); end
            checks++; if (res[32] !== exp[32]) begin errors++; $display("FAIL directed_cout[%0d]: got %b expected %b", i, res[32], exp[32]); end
            checks++; if (res[33] !== exp[33]) begin errors++; $display("FAIL directed_ovf[%0d]: got %b expected %b", i, res[33], exp[33]); end
        end
        checks++; if (model(32'h00FF_FFFF, 32'h1, 1'b0, 1'b0) !== {2'b00, 32'h0100_0000}) begin
            errors++; $display("FAIL model_sanity: reference disagrees with 0x01000000");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [6];
        logic [31:0] tb [6];
        logic        tc [6];
        logic [33:0] exp [6];
        logic [35:0] held;
        int          sent = 0, got = 0, last_ret = -1;
        held = '0;
        for (int i = 0; i < 6; i++) begin
            ta[i] = $urandom; tb[i] = $urandom; tc[i] = 1'($urandom % 2);
            exp[i] = model(ta[i], tb[i], tc[i], 1'b0);
        end
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 5 && cyc < 8);
            in_valid  = (sent < 6);
            sub_sig   = 1'b0;
            if (sent < 6) begin a = ta[sent]; b = tb[sent]; cin = tc[sent]; end
            #1;
            if (cyc >= 5 && cyc < 8) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_hold[%0d]: got %b expected 0", cyc, in_ready); end
                if (cyc == 5) held = {out_valid, ovf, cout, s};
                else begin
                    checks++;
                    if ({out_valid, ovf, cout, s} !== held) begin
                        errors++; $display("FAIL b2b_stall_stable[%0d]: got %h expected %h", cyc, {out_valid, ovf, cout, s}, held);
                    end
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checks++; if ({ovf, cout, s} !== exp[got]) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", got, {ovf, cout, s}, exp[got]); end
                if (cyc >= 8 && last_ret >= 8) begin
                    checks++; if (cyc != last_ret + 1) begin errors++; $display("FAIL b2b_throughput[%0d]: got cycle %0d expected %0d", got, cyc, last_ret + 1); end
                end
                last_ret = cyc;
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 6) begin errors++; $display("FAIL b2b_delivered: got %0d expected 6", got); end
    endtask

    task automatic test_random();
        logic [33:0] exp_q [$];
        logic [33:0] exp;
        logic [34:0] prev;
        logic        stalled = 1'b0;
        logic        ts;
        prev = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 360) begin
                in_valid  = ($urandom % 4) != 0;
                out_ready = ($urandom % 4) != 0;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
`ifdef ADDER_SUB_EN
            ts = 1'($urandom % 2);
`else
            ts = 1'b0;
`endif
            a = pick(); b = pick(); cin = 1'($urandom % 2); sub_sig = ts;
            #1;
            if (stalled) begin
                checks++;
                if ({out_valid, ovf, cout, s} !== {1'b1, prev[33:0]}) begin
                    errors++; $display("FAIL rand_stall_hold[%0d]: got %h expected %h", cyc, {out_valid, ovf, cout, s}, {1'b1, prev[33:0]});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, ts));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected[%0d]: got %h expected no result", cyc, {ovf, cout, s});
                end else begin
                    exp = exp_q.pop_front();
                    if ({ovf, cout, s} !== exp) begin errors++; $display("FAIL rand_result[%0d]: got %h expected %h", cyc, {ovf, cout, s}, exp); end
                end
            end
            stalled = out_valid && !out_ready;
            prev = {out_valid, ovf, cout, s};
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        logic [33:0] res, exp;
        int          lat;
        logic [31:0] na, nb;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom; cin = 1'b0; sub_sig = 1'b0;
            in_valid = 1'b1; out_ready = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b1; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_valid[%0d]: got %b expected 0", i, out_valid); end
            @(posedge clk); #1;
        end
        na = $urandom; nb = $urandom;
        send_one(na, nb, 1'b1, 1'b0, lat, res);
        exp = model(na, nb, 1'b1, 1'b0);
        checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency: got %0d expected 4", lat); end
        checks++; if (res !== exp) begin errors++; $display("FAIL midrst_result: got %h expected %h", res, exp); end
    endtask

`ifdef ADDER_SUB_EN
    task automatic test_sub();
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [33:0] res, exp;
        int          lat;
        va[0] = 32'h0000_0005; vb[0] = 32'h0000_0007;
        va[1] = 32'h8000_0000; vb[1] = 32'h0000_0001;
        for (int i = 0; i < 2; i++) begin
            send_one(va[i], vb[i], 1'b0, 1'b1, lat, res);
            exp = model(va[i], vb[i], 1'b0, 1'b1);
            checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency[%0d]: got %0d expected 4", i, lat); end
            checks++; if (res !== exp) begin errors++; $display("FAIL sub_result[%0d]: got %h expected %h", i, res, exp); end
        end
        sub_sig = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
`ifdef ADDER_SUB_EN
        test_sub();
`endif
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
